// File: rtl/du_word_tx_serializer.sv
// Debug-word transmit serializer: buffers 32-bit words in a small FIFO and feeds
// them byte by byte to the debug UART with a one-byte-in-flight start/done handshake.
module du_word_tx_serializer #(
  parameter int unsigned DWORD     = 32,
  parameter int unsigned BYTE      = 8,
  parameter int unsigned FIFO_ADDR = 3,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic [DWORD-1:0]     i_word,
  input  logic                 i_flush,
  input  logic                 i_tx_done,
  output logic [BYTE-1:0]      o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [FIFO_ADDR:0]   o_level,
  output logic                 o_busy,
  output logic                 o_word_sent,
  output logic                 o_overflow
);

  localparam int unsigned NBYTES = DWORD / BYTE;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned DEPTH  = 2 ** FIFO_ADDR;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [DWORD-1:0]     mem [DEPTH];
  logic [FIFO_ADDR-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR:0]   level_q;
  logic [DWORD-1:0]     shreg_q;
  logic [IDX_W-1:0]     byte_idx_q;
  logic                 push_ok, pop, advance, last_ack;

  function automatic logic [BYTE-1:0] sel_byte(input logic [DWORD-1:0] w, input int unsigned k);
    if (MSB_FIRST != 0) return BYTE'(w >> (DWORD - BYTE * (k + 1)));
    else                return BYTE'(w >> (BYTE * k));
  endfunction

  assign o_full  = (level_q == (FIFO_ADDR + 1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_busy  = (state_q != IDLE);
  assign push_ok = i_push && !o_full && !i_flush;

  always_ff @(posedge i_clock) begin
    if (push_ok) mem[wr_ptr] <= i_word;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      o_overflow <= 1'b0;
    end else if (i_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (i_push && o_full) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The word_sent cycle doubles as a one-cycle IDLE holdoff between words.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    advance    = 1'b0;
    last_ack   = 1'b0;
    o_tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!o_empty && !o_word_sent) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        o_tx_start = 1'b1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (byte_idx_q == IDX_W'(NBYTES - 1)) begin
            last_ack = 1'b1;
            state_d  = IDLE;
          end else begin
            advance = 1'b1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      o_tx_data   <= '0;
      o_word_sent <= 1'b0;
    end else begin
      o_word_sent <= last_ack;
      if (pop) begin
        shreg_q    <= mem[rd_ptr];
        byte_idx_q <= '0;
        o_tx_data  <= sel_byte(mem[rd_ptr], 0);
      end else if (advance) begin
        byte_idx_q <= byte_idx_q + 1'b1;
        o_tx_data  <= sel_byte(shreg_q, int'(byte_idx_q) + 1);
      end
    end
  end

endmodule

// File: tb/tb_du_word_tx_serializer.sv
// Directed bench for du_word_tx_serializer: LSB-first instance A, MSB-first instance B.
module tb_du_word_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        push_a, flush_a, done_a, push_b, flush_b, done_b;
  logic [31:0] word_a, word_b;
  logic [7:0]  data_a, data_b;
  logic        start_a, full_a, empty_a, busy_a, sent_a, ovf_a;
  logic        start_b, full_b, empty_b, busy_b, sent_b, ovf_b;
  logic [3:0]  level_a, level_b;

  int n_checks = 0;
  int n_fail   = 0;
  int starts_a = 0;
  int starts_b = 0;

  du_word_tx_serializer dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_push(push_a), .i_word(word_a), .i_flush(flush_a),
    .i_tx_done(done_a), .o_tx_data(data_a), .o_tx_start(start_a), .o_full(full_a),
    .o_empty(empty_a), .o_level(level_a), .o_busy(busy_a), .o_word_sent(sent_a),
    .o_overflow(ovf_a)
  );

  du_word_tx_serializer #(.MSB_FIRST(1)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_push(push_b), .i_word(word_b), .i_flush(flush_b),
    .i_tx_done(done_b), .o_tx_data(data_b), .o_tx_start(start_b), .o_full(full_b),
    .o_empty(empty_b), .o_level(level_b), .o_busy(busy_b), .o_word_sent(sent_b),
    .o_overflow(ovf_b)
  );

  always @(negedge clk) begin
    if (start_a) starts_a++;
    if (start_b) starts_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input bit sel, input logic [31:0] w);
    if (sel) begin push_b = 1'b1; word_b = w; end
    else     begin push_a = 1'b1; word_a = w; end
    tick();
    push_a = 1'b0;
    push_b = 1'b0;
  endtask

  task automatic ack(input bit sel);
    if (sel) done_b = 1'b1; else done_a = 1'b1;
    tick();
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  // seq holds the expected byte order, first byte in bits [31:24].
  task automatic serve(input bit sel, input logic [31:0] seq, input int k0, input int k1,
                       input string tag, output int waited);
    logic [7:0] exp_b;
    int w;
    waited = 0;
    for (int k = k0; k <= k1; k++) begin
      w = 0;
      while (!(sel ? start_b : start_a) && w < 30) begin
        tick();
        w++;
      end
      if (k == k0) waited = w;
      else check({tag, " byte gap"}, w, 0);
      exp_b = seq[31-8*k -: 8];
      check({tag, " start"}, sel ? start_b : start_a, 1);
      check({tag, " byte"}, sel ? data_b : data_a, exp_b);
      tick();
      check({tag, " start pulse"}, sel ? start_b : start_a, 0);
      tick();
      tick();
      check({tag, " byte stable"}, sel ? data_b : data_a, exp_b);
      ack(sel);
    end
    if (k1 == 3) begin
      check({tag, " word_sent"}, sel ? sent_b : sent_a, 1);
      check({tag, " idle"}, sel ? busy_b : busy_a, 0);
      tick();
      check({tag, " word_sent pulse"}, sel ? sent_b : sent_a, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, base;
    logic [31:0] seq;
    rst_n = 1'b0;
    push_a = 0; flush_a = 0; done_a = 0; word_a = '0;
    push_b = 0; flush_b = 0; done_b = 0; word_b = '0;
    tick(); tick(); tick();
    check("rst empty", empty_a, 1);
    check("rst full", full_a, 0);
    check("rst level", level_a, 0);
    check("rst busy", busy_a, 0);
    check("rst start", start_a, 0);
    check("rst data", data_a, 0);
    check("rst ovf", ovf_a, 0);
    check("rst sent", sent_a, 0);
    rst_n = 1'b1;
    tick();

    // Latency and LSB-first order
    base = starts_a;
    push_word(0, 32'hDEADBEEF);
    check("lat level", level_a, 1);
    check("lat empty", empty_a, 0);
    check("lat busy n+1", busy_a, 0);
    check("lat start n+1", start_a, 0);
    tick();
    check("lat busy n+2", busy_a, 1);
    check("lat level n+2", level_a, 0);
    check("lat start n+2", start_a, 1);
    serve(0, 32'hEFBEADDE, 0, 3, "deadbeef", w);
    check("deadbeef wait", w, 0);
    check("deadbeef starts", starts_a - base, 4);

    // Spurious done in IDLE and START
    done_a = 1'b1; tick(); done_a = 1'b0;
    check("spur idle busy", busy_a, 0);
    check("spur idle start", start_a, 0);
    base = starts_a;
    push_word(0, 32'hCAFEF00D);
    tick();
    check("spur start", start_a, 1);
    check("spur byte0", data_a, 8'h0D);
    done_a = 1'b1; tick(); done_a = 1'b0;
    check("spur wd start", start_a, 0);
    check("spur wd byte", data_a, 8'h0D);
    check("spur wd busy", busy_a, 1);
    tick();
    ack(0);
    serve(0, 32'h0DF0FECA, 1, 3, "spur", w);
    check("spur wait", w, 0);
    check("spur starts", starts_a - base, 4);

    // Overflow while UART stalled
    push_word(0, 32'hA0000000);
    tick();
    check("ovf w0 start", start_a, 1);
    check("ovf w0 byte", data_a, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      push_word(0, 32'hA0000000 + i);
      check("ovf level", level_a, (i <= 8) ? i : 8);
      check("ovf full", full_a, (i >= 8) ? 1 : 0);
      check("ovf flag", ovf_a, (i == 9) ? 1 : 0);
    end
    ack(0);
    serve(0, 32'h000000A0, 1, 3, "ovf w0", w);
    for (int i = 1; i <= 8; i++) begin
      seq = {i[7:0], 8'h00, 8'h00, 8'hA0};
      serve(0, seq, 0, 3, "ovf wn", w);
      check("ovf b2b wait", w, 1);
    end
    base = starts_a;
    repeat (30) tick();
    check("ovf 9th dropped", starts_a - base, 0);
    check("ovf drained empty", empty_a, 1);
    check("ovf sticky", ovf_a, 1);

    // Flush during first word
    push_word(0, 32'h76543210);
    tick();
    check("flush w1 start", start_a, 1);
    check("flush w1 byte", data_a, 8'h10);
    push_word(0, 32'h0F0F0F0F);
    push_word(0, 32'h12345678);
    check("flush pre level", level_a, 2);
    flush_a = 1'b1;
    push_word(0, 32'hEEEEEEEE);
    flush_a = 1'b0;
    check("flush level", level_a, 0);
    check("flush empty", empty_a, 1);
    check("flush ovf clr", ovf_a, 0);
    check("flush busy", busy_a, 1);
    ack(0);
    serve(0, 32'h10325476, 1, 3, "flush w1", w);
    base = starts_a;
    repeat (30) tick();
    check("flush no starts", starts_a - base, 0);

    // Reset mid-word
    push_word(0, 32'h11223344);
    tick();
    check("rstmid byte0", data_a, 8'h44);
    push_word(0, 32'h99999999);
    check("rstmid level", level_a, 1);
    ack(0);
    serve(0, 32'h44332211, 1, 1, "rstmid", w);
    check("rstmid 3rd start", start_a, 1);
    check("rstmid 3rd byte", data_a, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid start", start_a, 0);
    check("rstmid data", data_a, 0);
    check("rstmid busy", busy_a, 0);
    check("rstmid empty", empty_a, 1);
    check("rstmid lvl", level_a, 0);
    check("rstmid full", full_a, 0);
    check("rstmid sent", sent_a, 0);
    check("rstmid ovf", ovf_a, 0);
    base = starts_a;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rstmid no starts", starts_a - base, 0);
    push_word(0, 32'hAA55AA55);
    tick();
    serve(0, 32'h55AA55AA, 0, 3, "post rst", w);
    check("post rst wait", w, 0);

    // MSB-first instance
    base = starts_b;
    push_word(1, 32'h01020304);
    tick();
    serve(1, 32'h01020304, 0, 3, "msb", w);
    check("msb wait", w, 0);
    check("msb starts", starts_b - base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
